// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   hz_state_e : hazard controller state (RUN, LU_STALL, MEM_WAIT)
//   FWD_*      : ALU operand forwarding select codes
//   REG_AW     : register-index width
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding compare for one ALU operand.
// Ports:
//   src        in  AW  source register of the instruction in EX
//   mem_rd     in  AW  destination register in MEM
//   mem_regWr  in  1   MEM-stage write enable
//   wb_rd      in  AW  destination register in WB
//   wb_regWr   in  1   WB-stage write enable
//   sel        out 2   FWD_REG / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module fwd_unit
    import mips_pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_regWr,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_regWr,
    output logic [1:0]    sel
);

    logic mem_hit;
    logic wb_hit;

    // $0 is hardwired zero, so a write to it is never a real producer.
    assign mem_hit = mem_regWr && (mem_rd != '0) && (mem_rd == src);
    assign wb_hit  = wb_regWr  && (wb_rd  != '0) && (wb_rd  == src);

    // The MEM-stage result is younger, so it wins over WB.
    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and stall controller for the 5-stage MIPS pipeline.
// Drives PC / pipeline-register enables, flushes and ALU forwarding selects.
// Optional feature macro: HAZARD_PERF_EN (adds stall_cnt / flush_cnt).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal issue; all hazard rules apply
//   LU_STALL | one cycle with the load-use bubble in EX; lu_hz ignored
//   MEM_WAIT | data memory access outstanding, pipeline frozen
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   id_rs/id_rt, id_uses_rs/rt       ID-stage sources
//   id_jump                          jump decoded in ID
//   ex_rs/ex_rt/ex_rd, ex_regWr,
//   ex_Mem2Reg, ex_branch_taken      EX-stage info
//   mem_rd/mem_regWr, wb_rd/wb_regWr MEM/WB writers
//   mem_req, dmem_ready              data-memory handshake
//   *_en, ifid_flush, idex_flush,
//   memwb_bubble                     pipeline register control
//   fwd_a, fwd_b                     ALU operand selects
//   hz_state                         registered controller state
//   stall_cnt, flush_cnt             perf counters (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW = mips_pipe_pkg::REG_AW
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regWr,
    input  logic              ex_Mem2Reg,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_regWr,
    input  logic              wb_regWr,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    import mips_pipe_pkg::*;

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic       mem_wait;
    logic       lu_hz;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign mem_wait = mem_req && !dmem_ready;

    // The instruction held in ID during LU_STALL already saw this load once;
    // the EX fields may still look like the load, so the check is masked.
    assign lu_hz = (state_q != LU_STALL) && ex_regWr && ex_Mem2Reg &&
                   (ex_rd != '0) &&
                   ((id_uses_rs && (ex_rd == id_rs)) ||
                    (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        state_d      = RUN;

        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = MEM_WAIT;
        end else if (ex_branch_taken) begin
            // Squash both younger instructions; any lu_hz/jump is on the wrong path.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = LU_STALL;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .src       (ex_rs),
        .mem_rd    (mem_rd),
        .mem_regWr (mem_regWr),
        .wb_rd     (wb_rd),
        .wb_regWr  (wb_regWr),
        .sel       (fwd_a_raw)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .src       (ex_rt),
        .mem_rd    (mem_rd),
        .mem_regWr (mem_regWr),
        .wb_rd     (wb_rd),
        .wb_regWr  (wb_regWr),
        .sel       (fwd_b_raw)
    );

    assign fwd_a    = rst_n ? fwd_a_raw : FWD_REG;
    assign fwd_b    = rst_n ? fwd_b_raw : FWD_REG;
    assign hz_state = state_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if ((ifid_flush || idex_flush) && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios plus randomized stimulus against a rule-level model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, id_jump;
    logic       ex_regWr, ex_Mem2Reg, ex_branch_taken;
    logic       mem_regWr, wb_regWr, mem_req, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_bubble;
    logic [1:0] fwd_a, fwd_b, hz_state;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regWr(ex_regWr), .ex_Mem2Reg(ex_Mem2Reg), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regWr(mem_regWr), .wb_regWr(wb_regWr),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Grouped DUT outputs: {pc,ifid,idex,exmem,memwb} and {ifid_flush,idex_flush,bubble}
    logic [4:0] en_v;
    logic [2:0] fl_v;
    assign en_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl_v = {ifid_flush, idex_flush, memwb_bubble};

    // ---------------- reference model (rule level) ----------------
    int ms;            // model state: 0 run, 1 just stalled on load-use, 2 waiting
    int m_stall, m_flush;
    logic [4:0] x_en;
    logic [2:0] x_fl;
    logic [1:0] x_fa, x_fb;
    int x_next;

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (mem_regWr && mem_rd != 0 && mem_rd == src) return 2'b01;
        if (wb_regWr && wb_rd != 0 && wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic ref_eval();
        bit mw, lu;
        mw = mem_req && !dmem_ready;
        lu = (ms != 1) && ex_regWr && ex_Mem2Reg && ex_rd != 0 &&
             ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
        x_fa = ref_fwd(ex_rs);
        x_fb = ref_fwd(ex_rt);
        x_next = 0;
        if (!rst_n) begin
            x_en = 5'b00000; x_fl = 3'b111; x_fa = 2'b00; x_fb = 2'b00;
        end else if (mw) begin
            x_en = 5'b00000; x_fl = 3'b000; x_next = 2;
        end else if (ex_branch_taken) begin
            x_en = 5'b11111; x_fl = 3'b110;
        end else if (lu) begin
            x_en = 5'b00111; x_fl = 3'b010; x_next = 1;
        end else if (id_jump) begin
            x_en = 5'b11111; x_fl = 3'b100;
        end else begin
            x_en = 5'b11111; x_fl = 3'b000;
        end
    endtask

    task automatic ref_clock();
        if (!rst_n) begin
            ms = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!x_en[4] && m_stall < 65535) m_stall++;
            if ((x_fl[2] || x_fl[1]) && m_flush < 65535) m_flush++;
            ms = x_next;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic idle();
        rst_n = 1; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regWr = 0; ex_Mem2Reg = 0; ex_branch_taken = 0;
        mem_rd = 0; wb_rd = 0; mem_regWr = 0; wb_regWr = 0; mem_req = 0; dmem_ready = 1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        mem_regWr = 1; mem_rd = 3; ex_rs = 3;
        step();
        #1;
        n_total++;
        if (hz_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", hz_state);
        else n_pass++;
        n_total++;
        if (en_v !== 5'b00000 || fl_v !== 3'b111 || fwd_a !== 2'b00)
            $display("FAIL reset_outputs: en=%b fl=%b fwd_a=%b want en=00000 fl=111 fwd_a=00", en_v, fl_v, fwd_a);
        else n_pass++;
        idle();
        step();
    endtask

    task automatic test_load_use();
        idle();
        ex_regWr = 1; ex_Mem2Reg = 1; ex_rd = 2;
        id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
        #1;
        n_total++;
        if (en_v !== 5'b00111 || fl_v !== 3'b010)
            $display("FAIL lu_stall: en=%b fl=%b want en=00111 fl=010", en_v, fl_v);
        else n_pass++;
        step();
        // Stale load info left in EX must not stall a second time.
        mem_rd = 2; mem_regWr = 1; mem_req = 1; dmem_ready = 1;
        #1;
        n_total++;
        if (hz_state !== 2'd1) $display("FAIL lu_state: got %0d want 1", hz_state);
        else n_pass++;
        n_total++;
        if (en_v !== 5'b11111 || fl_v !== 3'b000)
            $display("FAIL lu_single_bubble: en=%b fl=%b want en=11111 fl=000", en_v, fl_v);
        else n_pass++;
        step();
        idle();
        ex_rs = 2; ex_rt = 4; wb_rd = 2; wb_regWr = 1;
        #1;
        n_total++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00 || hz_state !== 2'd0)
            $display("FAIL lu_fwd: fwd_a=%b fwd_b=%b st=%0d want 10 00 0", fwd_a, fwd_b, hz_state);
        else n_pass++;
        step();
    endtask

    task automatic test_forward();
        idle();
        ex_rs = 2; ex_rt = 2; mem_rd = 2; mem_regWr = 1; wb_rd = 2; wb_regWr = 1;
        id_rs = 2; id_uses_rs = 1;
        #1;
        n_total++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || pc_en !== 1'b1)
            $display("FAIL fwd_exmem: fwd_a=%b fwd_b=%b pc_en=%b want 01 01 1", fwd_a, fwd_b, pc_en);
        else n_pass++;
        ex_rt = 5; wb_rd = 5;
        #1;
        n_total++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b10)
            $display("FAIL fwd_split: fwd_a=%b fwd_b=%b want 01 10", fwd_a, fwd_b);
        else n_pass++;
        mem_regWr = 0; wb_regWr = 0;
        #1;
        n_total++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00)
            $display("FAIL fwd_nowr: fwd_a=%b fwd_b=%b want 00 00", fwd_a, fwd_b);
        else n_pass++;
        step();
    endtask

    task automatic test_branch_priority();
        idle();
        ex_branch_taken = 1; id_jump = 1;
        ex_regWr = 1; ex_Mem2Reg = 1; ex_rd = 7; id_rs = 7; id_uses_rs = 1;
        #1;
        n_total++;
        if (en_v !== 5'b11111 || fl_v !== 3'b110)
            $display("FAIL branch_prio: en=%b fl=%b want en=11111 fl=110", en_v, fl_v);
        else n_pass++;
        step();
        idle();
        id_jump = 1;
        #1;
        n_total++;
        if (hz_state !== 2'd0 || en_v !== 5'b11111 || fl_v !== 3'b100)
            $display("FAIL jump: st=%0d en=%b fl=%b want 0 11111 100", hz_state, en_v, fl_v);
        else n_pass++;
        step();
    endtask

    task automatic test_mem_wait();
        int s0;
`ifdef HAZARD_PERF_EN
        s0 = int'(stall_cnt);
`else
        s0 = 0;
`endif
        idle();
        mem_req = 1; dmem_ready = 0;
        ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (en_v !== 5'b00000 || fl_v !== 3'b000)
                $display("FAIL wait_freeze[%0d]: en=%b fl=%b want 00000 000", i, en_v, fl_v);
            else n_pass++;
            step();
            n_total++;
            if (hz_state !== 2'd2) $display("FAIL wait_state[%0d]: got %0d want 2", i, hz_state);
            else n_pass++;
        end
        dmem_ready = 1;
        #1;
        n_total++;
        if (en_v !== 5'b11111 || fl_v !== 3'b110)
            $display("FAIL wait_release: en=%b fl=%b want 11111 110", en_v, fl_v);
        else n_pass++;
        step();
        n_total++;
        if (hz_state !== 2'd0) $display("FAIL wait_exit: got %0d want 0", hz_state);
        else n_pass++;
`ifdef HAZARD_PERF_EN
        n_total++;
        if (int'(stall_cnt) !== s0 + 3)
            $display("FAIL wait_stall_cnt: got %0d want %0d", stall_cnt, s0 + 3);
        else n_pass++;
`endif
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        idle();
        ex_regWr = 1; ex_Mem2Reg = 1; ex_rd = 0;
        id_rs = 0; id_rt = 0; id_uses_rs = 1; id_uses_rt = 1;
        ex_rs = 0; ex_rt = 0; mem_rd = 0; mem_regWr = 1; wb_rd = 0; wb_regWr = 1;
        #1;
        n_total++;
        if (en_v !== 5'b11111 || fl_v !== 3'b000 || fwd_a !== 2'b00 || fwd_b !== 2'b00)
            $display("FAIL zero_reg: en=%b fl=%b fa=%b fb=%b want 11111 000 00 00", en_v, fl_v, fwd_a, fwd_b);
        else n_pass++;
        step();
        n_total++;
        if (hz_state !== 2'd0) $display("FAIL zero_reg_state: got %0d want 0", hz_state);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        idle();
        mem_req = 1; dmem_ready = 0;
        step();
        n_total++;
        if (hz_state !== 2'd2) $display("FAIL rmw_enter: got %0d want 2", hz_state);
        else n_pass++;
        rst_n = 0;
        #1;
        n_total++;
        if (en_v !== 5'b00000 || fl_v !== 3'b111)
            $display("FAIL rmw_forced: en=%b fl=%b want 00000 111", en_v, fl_v);
        else n_pass++;
        step();
        rst_n = 1;
        #1;
        n_total++;
        if (hz_state !== 2'd0) $display("FAIL rmw_state: got %0d want 0", hz_state);
        else n_pass++;
`ifdef HAZARD_PERF_EN
        n_total++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL rmw_counters: stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
        else n_pass++;
`endif
        idle();
        step();
    endtask

    task automatic test_random();
        idle();
        rst_n = 0;
        step();
        ms = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 400; c++) begin
            rst_n           = ($urandom_range(0, 40) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_jump         = ($urandom_range(0, 5) == 0);
            ex_rs           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_regWr        = 1'($urandom_range(0, 1));
            ex_Mem2Reg      = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            mem_rd          = 5'($urandom_range(0, 3));
            wb_rd           = 5'($urandom_range(0, 3));
            mem_regWr       = 1'($urandom_range(0, 1));
            wb_regWr        = 1'($urandom_range(0, 1));
            mem_req         = ($urandom_range(0, 2) == 0);
            dmem_ready      = ($urandom_range(0, 2) != 0);
            #1;
            ref_eval();
            n_total++;
            if (hz_state !== 2'(ms)) $display("FAIL rnd_state c=%0d: got %0d want %0d", c, hz_state, ms);
            else n_pass++;
            n_total++;
            if (en_v !== x_en) $display("FAIL rnd_en c=%0d: got %b want %b", c, en_v, x_en);
            else n_pass++;
            n_total++;
            if (fl_v !== x_fl) $display("FAIL rnd_flush c=%0d: got %b want %b", c, fl_v, x_fl);
            else n_pass++;
            n_total++;
            if (fwd_a !== x_fa || fwd_b !== x_fb)
                $display("FAIL rnd_fwd c=%0d: got %b/%b want %b/%b", c, fwd_a, fwd_b, x_fa, x_fb);
            else n_pass++;
`ifdef HAZARD_PERF_EN
            n_total++;
            if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush)
                $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush);
            else n_pass++;
`endif
            @(posedge clk);
            ref_clock();
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_forward();
        test_branch_priority();
        test_mem_wait();
        test_zero_reg();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline. It sits beside the instruction decoder and drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also drives the ALU operand forwarding selects. It handles four conditions: load-use interlock, taken-branch and jump flush, data-memory wait freeze, and operand forwarding.

## Interface
Parameters:
- REG_AW, 5, register-index width
- CNT_W, 16, width of the performance counters (only with HAZARD_PERF_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_jump  in  1  decoder jump flag for the instruction in ID
- ex_rs, ex_rt  in  REG_AW  source registers of the instruction in EX
- ex_rd  in  REG_AW  destination register in EX (after the regDst mux)
- ex_regWr, ex_Mem2Reg  in  1  EX-stage write enable and load flag
- ex_branch_taken  in  1  branch resolved taken in EX (beq/bne result)
- mem_rd, wb_rd  in  REG_AW  destination registers in MEM and WB
- mem_regWr, wb_regWr  in  1  write enables in MEM and WB
- mem_req  in  1  MEM stage is accessing data memory (lw/sw)
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush, memwb_bubble  out  1  insert a NOP into the register
- fwd_a, fwd_b  out  2  ALU A/B source: 00 register file, 01 EX/MEM, 10 MEM/WB
- hz_state  out  2  current state: RUN=0, LU_STALL=1, MEM_WAIT=2
- stall_cnt, flush_cnt  out  CNT_W  performance counters (HAZARD_PERF_EN only)

## Operation
- Hazard terms:
  - mem_wait = mem_req & ~dmem_ready
  - lu_hz = ex_regWr & ex_Mem2Reg & (ex_rd≠0) & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt))
- Priority is mem_wait > ex_branch_taken > lu_hz > id_jump.
- mem_wait: all five enables are 0. No flush and no bubble is asserted. Next state is MEM_WAIT.
- ex_branch_taken (and no mem_wait): all enables are 1, ifid_flush=1 and idex_flush=1. A coincident lu_hz or id_jump is discarded. Next state is RUN.
- lu_hz: pc_en=0, ifid_en=0, idex_flush=1, and the other enables are 1. Next state is LU_STALL.
- id_jump: all enables are 1 and ifid_flush=1.
- Otherwise: all enables are 1 and no flushes are asserted.
- State behaviour:
  - RUN: the rules above apply.
  - LU_STALL: lasts exactly one cycle, while the bubble is in EX. lu_hz is ignored in this state; mem_wait and branch rules still apply. Returns to RUN.
  - MEM_WAIT: holds until dmem_ready=1. On the release cycle, memwb_bubble=0 and the enables follow RUN rules. A branch still held in EX then flushes normally.
- Forwarding, evaluated independently for A (ex_rs) and B (ex_rt):
  - 01 when mem_regWr & mem_rd≠0 & mem_rd matches the source.
  - Otherwise 10 when wb_regWr & wb_rd≠0 & wb_rd matches.
  - Otherwise 00.
  - EX/MEM wins when both match.
- Register $0 never causes a hazard or a forward.

## Timing
- Enables, flushes and fwd_* are combinational from hz_state and the inputs. They take effect at the next rising edge.
- hz_state is registered.
- A load-use stall inserts exactly one bubble; the dependent instruction issues into EX 2 cycles after the load did.
- A taken branch costs 2 squashed instructions. A jump costs 1.
- Reset: while rst_n=0 at an edge, hz_state becomes RUN. While rst_n=0, the outputs are forced to all enables 0, ifid_flush=idex_flush=memwb_bubble=1 and fwd_*=00.
- Reset asserted mid-stall or mid-wait abandons the stall or wait. The first cycle after reset is RUN.
- dmem_ready may stay high permanently; in that case MEM_WAIT is never entered.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on each cycle with pc_en=0.
  - flush_cnt increments on each cycle with ifid_flush=1 or idex_flush=1.
  - Both counters saturate at all-ones and clear on reset.
- HAZARD_PERF_EN undefined: the counter ports and their logic are absent.

## Structure
- Shared package mips_pipe_pkg holds:
  - the hz_state enum (RUN, LU_STALL, MEM_WAIT)
  - the forward-select constants FWD_REG, FWD_EXMEM, FWD_MEMWB
  - REG_AW
- One sub-module: fwd_unit, the combinational forwarding compare, instantiated once per operand.

## Test plan
- lw $2,0($1) followed by add $3,$2,$4 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle hz_state=1; fwd_a=10 on the add's EX cycle.
- add $2,.. followed by sub $5,$2,$2 -> fwd_a=fwd_b=01, no stall.
- beq taken in EX with lu_hz in ID in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, hz_state stays 0.
- sw with dmem_ready low for 3 cycles -> all enables 0 for 3 cycles, hz_state=2, release on the 4th cycle; stall_cnt=3 (HAZARD_PERF_EN).
- lw with ex_rd=0 and a dependent instruction in ID -> no stall, fwd=00.
- rst_n=0 during MEM_WAIT -> next cycle hz_state=0, counters 0.
